// File: rtl/vdma_axi_pkg.sv
// vdma_axi_pkg: shared AXI response codes, response merge and burst-splitter FSM states
package vdma_axi_pkg;
  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_EXOKAY = 2'b01;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;
  localparam logic [12:0] BOUNDARY_4K = 13'd4096;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_WAITB, S_SRESP} state_t;
  function automatic logic [1:0] bresp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/burst_len_calc.sv
// burst_len_calc: sub-burst length limited by 4 KB boundary and MAX_BEATS, plus following address
module burst_len_calc import vdma_axi_pkg::*; #(
  parameter int ASIZE     = 29,
  parameter int LSIZE     = 9,
  parameter int BYTES     = 32,
  parameter int MAX_BEATS = 128
) (
  input  logic [ASIZE-1:0] addr,
  input  logic [LSIZE:0]   remain,
  output logic [LSIZE:0]   sub,
  output logic [ASIZE-1:0] next_addr
);
  localparam int BW = $clog2(BYTES);
  localparam int CW = (LSIZE + 1 > 13) ? LSIZE + 1 : 13;
  logic [CW-1:0] to_bound;
  logic [CW-1:0] rem_w;
  logic [CW-1:0] lim;
  assign to_bound  = CW'((BOUNDARY_4K - {1'b0, addr[11:0]}) >> BW);
  assign rem_w     = CW'(remain);
  assign lim       = (to_bound < CW'(MAX_BEATS)) ? to_bound : CW'(MAX_BEATS);
  assign sub       = (LSIZE+1)'((rem_w < lim) ? rem_w : lim);
  assign next_addr = addr + (ASIZE'(sub) << BW);
endmodule

// File: rtl/axi_wr_burst_split.sv
// axi_wr_burst_split: splits one AXI4 write burst into 4 KB-safe sub-bursts and merges their B responses
module axi_wr_burst_split import vdma_axi_pkg::*; #(
  parameter int ASIZE     = 29,
  parameter int LSIZE     = 9,
  parameter int AXI_DSIZE = 256,
  parameter int IDSIZE    = 4,
  parameter int MAX_BEATS = 128
) (
  input  logic                   axi_aclk,
  input  logic                   axi_reset,
  input  logic [IDSIZE-1:0]      s_axi_awid,
  input  logic [ASIZE-1:0]       s_axi_awaddr,
  input  logic [LSIZE-1:0]       s_axi_awlen,
  input  logic [2:0]             s_axi_awsize,
  input  logic [1:0]             s_axi_awburst,
  input  logic                   s_axi_awlock,
  input  logic [3:0]             s_axi_awcache,
  input  logic [2:0]             s_axi_awprot,
  input  logic [3:0]             s_axi_awqos,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [AXI_DSIZE-1:0]   s_axi_wdata,
  input  logic [AXI_DSIZE/8-1:0] s_axi_wstrb,
  input  logic                   s_axi_wlast,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [IDSIZE-1:0]      s_axi_bid,
  output logic [1:0]             s_axi_bresp,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  output logic [IDSIZE-1:0]      m_axi_awid,
  output logic [ASIZE-1:0]       m_axi_awaddr,
  output logic [LSIZE-1:0]       m_axi_awlen,
  output logic [2:0]             m_axi_awsize,
  output logic [1:0]             m_axi_awburst,
  output logic                   m_axi_awlock,
  output logic [3:0]             m_axi_awcache,
  output logic [2:0]             m_axi_awprot,
  output logic [3:0]             m_axi_awqos,
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,
  output logic [AXI_DSIZE-1:0]   m_axi_wdata,
  output logic [AXI_DSIZE/8-1:0] m_axi_wstrb,
  output logic                   m_axi_wlast,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,
  input  logic [IDSIZE-1:0]      m_axi_bid,
  input  logic [1:0]             m_axi_bresp,
  input  logic                   m_axi_bvalid,
  output logic                   m_axi_bready
);
  localparam int BYTES = AXI_DSIZE / 8;
  localparam int BW    = $clog2(BYTES);
  localparam int CNTW  = $clog2(2**LSIZE + 1);
  state_t            state, state_nx;
  logic [IDSIZE-1:0] id_r;
  logic [ASIZE-1:0]  addr_r;
  logic [2:0]        size_r;
  logic [1:0]        burst_r;
  logic              lock_r;
  logic [3:0]        cache_r;
  logic [2:0]        prot_r;
  logic [3:0]        qos_r;
  logic [LSIZE:0]    remain_r, sub_r, beat_r, sub;
  logic [CNTW-1:0]   issued_r, bcnt_r;
  logic [1:0]        resp_r;
  logic              werr_r;
  logic [ASIZE-1:0]  next_addr;
  logic              aw_hs, maw_hs, w_hs, b_hs, last_beat, up_last;
  logic              unused;
  burst_len_calc #(.ASIZE(ASIZE), .LSIZE(LSIZE), .BYTES(BYTES), .MAX_BEATS(MAX_BEATS)) u_len (
    .addr(addr_r), .remain(remain_r), .sub(sub), .next_addr(next_addr)
  );
  assign unused    = ^{m_axi_bid, s_axi_awaddr[BW-1:0]};
  assign aw_hs     = (state == S_IDLE) && s_axi_awvalid;
  assign maw_hs    = (state == S_ADDR) && m_axi_awready;
  assign w_hs      = (state == S_DATA) && s_axi_wvalid && m_axi_wready;
  assign b_hs      = (state != S_IDLE) && m_axi_bvalid;
  assign last_beat = beat_r == sub_r - (LSIZE+1)'(1);
  assign up_last   = last_beat && (remain_r == '0);
  assign m_axi_awid    = id_r;
  assign m_axi_awaddr  = addr_r;
  assign m_axi_awlen   = (state == S_ADDR) ? LSIZE'(sub - (LSIZE+1)'(1)) : '0;
  assign m_axi_awsize  = size_r;
  assign m_axi_awburst = burst_r;
  assign m_axi_awlock  = lock_r;
  assign m_axi_awcache = cache_r;
  assign m_axi_awprot  = prot_r;
  assign m_axi_awqos   = qos_r;
  assign m_axi_bready  = state != S_IDLE;
  assign s_axi_bid     = id_r;
  assign s_axi_bresp   = bresp_max(resp_r, werr_r ? BRESP_SLVERR : BRESP_OKAY);
  always_ff @(posedge axi_aclk)
    state <= axi_reset ? S_IDLE : state_nx;
  always_comb begin
    state_nx      = state;
    s_axi_awready = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    s_axi_wready  = 1'b0;
    m_axi_wdata   = '0;
    m_axi_wstrb   = '0;
    m_axi_wlast   = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (state)
      S_IDLE: begin
        s_axi_awready = !axi_reset;
        if (s_axi_awvalid) state_nx = S_ADDR;
      end
      S_ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_nx = S_DATA;
      end
      S_DATA: begin
        m_axi_wvalid = s_axi_wvalid;
        s_axi_wready = m_axi_wready;
        m_axi_wdata  = s_axi_wdata;
        m_axi_wstrb  = s_axi_wstrb;
        m_axi_wlast  = last_beat;
        if (w_hs && last_beat) state_nx = (remain_r != '0) ? S_ADDR : S_WAITB;
      end
      S_WAITB: if (bcnt_r == issued_r) state_nx = S_SRESP;
      S_SRESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      id_r     <= '0;
      addr_r   <= '0;
      size_r   <= '0;
      burst_r  <= '0;
      lock_r   <= 1'b0;
      cache_r  <= '0;
      prot_r   <= '0;
      qos_r    <= '0;
      remain_r <= '0;
      sub_r    <= '0;
      beat_r   <= '0;
      issued_r <= '0;
      bcnt_r   <= '0;
      resp_r   <= BRESP_OKAY;
      werr_r   <= 1'b0;
    end else begin
      if (aw_hs) begin
        id_r     <= s_axi_awid;
        addr_r   <= {s_axi_awaddr[ASIZE-1:BW], BW'(0)};
        size_r   <= s_axi_awsize;
        burst_r  <= s_axi_awburst;
        lock_r   <= s_axi_awlock;
        cache_r  <= s_axi_awcache;
        prot_r   <= s_axi_awprot;
        qos_r    <= s_axi_awqos;
        remain_r <= {1'b0, s_axi_awlen} + (LSIZE+1)'(1);
      end
      if (maw_hs) begin
        addr_r   <= next_addr;
        remain_r <= remain_r - sub;
        sub_r    <= sub;
        beat_r   <= '0;
        issued_r <= issued_r + CNTW'(1);
      end
      // beat count follows awlen; a wlast that disagrees only raises the sticky error
      if (w_hs) begin
        beat_r <= beat_r + (LSIZE+1)'(1);
        if (s_axi_wlast != up_last) werr_r <= 1'b1;
      end
      if (b_hs) begin
        bcnt_r <= bcnt_r + CNTW'(1);
        resp_r <= bresp_max(resp_r, m_axi_bresp);
      end
      if (state == S_SRESP && s_axi_bready) begin
        issued_r <= '0;
        bcnt_r   <= '0;
        resp_r   <= BRESP_OKAY;
        werr_r   <= 1'b0;
      end
    end
  end
endmodule
